// File: rtl/voice_scan_allocator.sv
// Frame-based voice allocator: scans one note group per cycle, admits up to NUM_VOICES
// gated notes, and publishes a coherent snapshot of the admitted set at each COMMIT slot.
module voice_scan_allocator #(
    parameter int ADDR_WIDTH  = 8,
    parameter int PHASE_WIDTH = 32,
    parameter int NUM_NOTES   = 24,
    parameter int NUM_GROUPS  = 3,
    parameter int NUM_VOICES  = 8,
    localparam int IDX_WIDTH  = $clog2(NUM_NOTES + 1),
    localparam int VCNT_WIDTH = $clog2(NUM_VOICES + 1)
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [PHASE_WIDTH-1:0] phase_in [NUM_NOTES],
    input  logic [NUM_NOTES-1:0]   gate_in,
    input  logic [NUM_GROUPS-1:0]  group_en_in,
    input  logic                   rr_mode_in,
    output logic [ADDR_WIDTH-1:0]  addr_out [NUM_NOTES],
    output logic [VCNT_WIDTH-1:0]  num_voices_out,
    output logic [NUM_NOTES-1:0]   active_voices_out,
    output logic [IDX_WIDTH-1:0]   active_voices_idx_out [NUM_VOICES],
    output logic                   frame_valid_out,
    output logic                   overflow_out,
    output logic [IDX_WIDTH-1:0]   dropped_out
);
    localparam int NPG = NUM_NOTES / NUM_GROUPS;
    localparam int GW  = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int SW  = $clog2(NUM_GROUPS + 1);
    localparam int VIW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [VCNT_WIDTH-1:0] VMAX      = VCNT_WIDTH'(NUM_VOICES);
    localparam logic [IDX_WIDTH-1:0]  IDX_EMPTY = '1;
    localparam logic [SW-1:0]         COMMIT    = SW'(NUM_GROUPS);

    logic [SW-1:0]         slot_q, slot_d;
    logic [GW-1:0]         start_grp_q, start_grp_d;
    logic [GW:0]           gsum;
    logic [GW-1:0]         grp;
    int unsigned           n;

    // Frame accumulators
    logic [VCNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [NUM_NOTES-1:0]  mask_q, mask_d;
    logic [IDX_WIDTH-1:0]  map_q [NUM_VOICES];
    logic [IDX_WIDTH-1:0]  map_d [NUM_VOICES];
    logic [IDX_WIDTH-1:0]  drops_q, drops_d;

    // Published state
    logic [ADDR_WIDTH-1:0] addr_q [NUM_NOTES];
    logic [ADDR_WIDTH-1:0] addr_d [NUM_NOTES];
    logic [VCNT_WIDTH-1:0] num_q, num_d;
    logic [NUM_NOTES-1:0]  act_q, act_d;
    logic [IDX_WIDTH-1:0]  idx_q [NUM_VOICES];
    logic [IDX_WIDTH-1:0]  idx_d [NUM_VOICES];
    logic                  fv_q, fv_d;
    logic                  ovf_q, ovf_d;
    logic [IDX_WIDTH-1:0]  dropped_q, dropped_d;

    // Group handled this slot, rotated by start_grp
    always_comb begin
        gsum = {1'b0, start_grp_q} + (GW + 1)'(slot_q);
        if (gsum >= (GW + 1)'(NUM_GROUPS)) begin
            gsum = gsum - (GW + 1)'(NUM_GROUPS);
        end
        grp = gsum[GW-1:0];
    end

    always_comb begin
        slot_d      = slot_q;
        start_grp_d = start_grp_q;
        cnt_d       = cnt_q;
        mask_d      = mask_q;
        map_d       = map_q;
        drops_d     = drops_q;
        addr_d      = addr_q;
        num_d       = num_q;
        act_d       = act_q;
        idx_d       = idx_q;
        fv_d        = 1'b0;
        ovf_d       = ovf_q;
        dropped_d   = dropped_q;
        n           = 0;

        if (slot_q == COMMIT) begin
            num_d     = cnt_q;
            act_d     = mask_q;
            idx_d     = map_q;
            dropped_d = drops_q;
            ovf_d     = (drops_q != '0);
            fv_d      = 1'b1;
            cnt_d     = '0;
            mask_d    = '0;
            drops_d   = '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                map_d[v] = IDX_EMPTY;
            end
            if (rr_mode_in && (start_grp_q != GW'(NUM_GROUPS - 1))) begin
                start_grp_d = start_grp_q + 1'b1;
            end else begin
                start_grp_d = '0;
            end
            slot_d = '0;
        end else begin
            for (int j = 0; j < NPG; j++) begin
                n = int'(grp) * NPG + j;
                addr_d[n] = '0;
                if (group_en_in[grp] && gate_in[n]) begin
                    if (cnt_d < VMAX) begin
                        addr_d[n]          = phase_in[n][PHASE_WIDTH-1 -: ADDR_WIDTH];
                        map_d[VIW'(cnt_d)] = IDX_WIDTH'(n);
                        mask_d[n]          = 1'b1;
                        cnt_d              = cnt_d + 1'b1;
                    end else if (drops_d != IDX_EMPTY) begin
                        drops_d = drops_d + 1'b1;
                    end
                end
            end
            slot_d = slot_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            slot_q      <= '0;
            start_grp_q <= '0;
            cnt_q       <= '0;
            mask_q      <= '0;
            drops_q     <= '0;
            num_q       <= '0;
            act_q       <= '0;
            fv_q        <= 1'b0;
            ovf_q       <= 1'b0;
            dropped_q   <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                map_q[v] <= IDX_EMPTY;
                idx_q[v] <= IDX_EMPTY;
            end
            for (int i = 0; i < NUM_NOTES; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            slot_q      <= slot_d;
            start_grp_q <= start_grp_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            map_q       <= map_d;
            drops_q     <= drops_d;
            addr_q      <= addr_d;
            num_q       <= num_d;
            act_q       <= act_d;
            idx_q       <= idx_d;
            fv_q        <= fv_d;
            ovf_q       <= ovf_d;
            dropped_q   <= dropped_d;
        end
    end

    // Only the top ADDR_WIDTH phase bits feed the datapath
    logic unused_phase;
    always_comb begin
        unused_phase = 1'b0;
        for (int i = 0; i < NUM_NOTES; i++) begin
            unused_phase = unused_phase ^ (^phase_in[i]);
        end
    end

    assign addr_out              = addr_q;
    assign num_voices_out        = num_q;
    assign active_voices_out     = act_q;
    assign active_voices_idx_out = idx_q;
    assign frame_valid_out       = fv_q;
    assign overflow_out          = ovf_q;
    assign dropped_out           = dropped_q;
endmodule

// File: tb/tb_voice_scan_allocator.sv
// Bench for voice_scan_allocator: queue-based frame model checked every cycle, plus directed literals.
module tb_voice_scan_allocator;
    localparam int NN = 24;
    localparam int NG = 3;
    localparam int NV = 8;
    localparam int NPG = NN / NG;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] phase [NN];
    logic [NN-1:0] gate;
    logic [NG-1:0] gen;
    logic        rr;
    logic [7:0]  addr [NN];
    logic [3:0]  num;
    logic [NN-1:0] mask;
    logic [4:0]  idx [NV];
    logic        fv;
    logic        ovf;
    logic [4:0]  dropped;

    int total = 0;
    int bad = 0;

    voice_scan_allocator dut (
        .clk_in(clk), .rst_in(rst), .phase_in(phase), .gate_in(gate),
        .group_en_in(gen), .rr_mode_in(rr), .addr_out(addr),
        .num_voices_out(num), .active_voices_out(mask),
        .active_voices_idx_out(idx), .frame_valid_out(fv),
        .overflow_out(ovf), .dropped_out(dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a frame is a list of groups in rotated order, admission is a queue.
    int  m_slot, m_start, m_drops;
    int  acc[$];
    bit  m_live = 0;
    int  e_addr [NN];
    int  e_num, e_drop;
    logic [NN-1:0] e_mask;
    int  e_map [NV];
    bit  e_fv, e_ovf;

    always @(posedge clk) begin
        if (rst) begin
            m_live = 1; m_slot = 0; m_start = 0; m_drops = 0; acc = {};
            foreach (e_addr[i]) e_addr[i] = 0;
            e_num = 0; e_drop = 0; e_mask = '0; e_fv = 0; e_ovf = 0;
            foreach (e_map[v]) e_map[v] = 31;
        end else if (m_live) begin
            e_fv = 0;
            if (m_slot < NG) begin
                int g;
                g = (m_start + m_slot) % NG;
                for (int k = 0; k < NPG; k++) begin
                    int nt;
                    nt = g * NPG + k;
                    e_addr[nt] = 0;
                    if (gen[g] && gate[nt]) begin
                        if (acc.size() < NV) begin
                            acc.push_back(nt);
                            e_addr[nt] = int'(phase[nt] >> 24);
                        end else if (m_drops < 31) begin
                            m_drops++;
                        end
                    end
                end
                m_slot++;
            end else begin
                e_num = acc.size();
                e_mask = '0;
                foreach (e_map[v]) e_map[v] = (v < acc.size()) ? acc[v] : 31;
                foreach (acc[q]) e_mask[acc[q]] = 1'b1;
                e_drop = m_drops;
                e_ovf = (m_drops != 0);
                e_fv = 1;
                acc = {}; m_drops = 0; m_slot = 0;
                m_start = rr ? (m_start + 1) % NG : 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("fv", 64'(fv), 64'(e_fv));
            chk("num", 64'(num), 64'(e_num));
            chk("mask", 64'(mask), 64'(e_mask));
            chk("drop", 64'(dropped), 64'(e_drop));
            chk("ovf", 64'(ovf), 64'(e_ovf));
            for (int v = 0; v < NV; v++) chk($sformatf("map%0d", v), 64'(idx[v]), 64'(e_map[v]));
            for (int i = 0; i < NN; i++) chk($sformatf("addr%0d", i), 64'(addr[i]), 64'(e_addr[i]));
        end
    end

    // Runs one full frame from slot 0; returns #1 after the COMMIT edge.
    task automatic frame(input string tag);
        repeat (NG + 1) @(posedge clk);
        #1;
        chk({tag, "_strobe"}, 64'(fv), 64'd1);
        $display("frame %s: num=%0d mask=%06h drop=%0d ovf=%0d", tag, num, mask, dropped, ovf);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; gate = '0; gen = 3'b111; rr = 0;
        foreach (phase[i]) phase[i] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // T1: empty frame, strobe after the 4th edge
        repeat (3) @(posedge clk);
        #1 chk("t1_no_early_strobe", 64'(fv), 64'd0);
        frame_tail: begin end
        @(posedge clk); #1;
        chk("t1_strobe", 64'(fv), 64'd1);
        chk("t1_num", 64'(num), 64'd0);
        chk("t1_map0", 64'(idx[0]), 64'd31);
        chk("t1_map7", 64'(idx[7]), 64'd31);
        $display("frame t1: num=%0d", num);

        // T2: three sparse notes
        gate = '0; gate[1] = 1; gate[9] = 1; gate[17] = 1;
        phase[1] = 32'hAB000000; phase[9] = 32'h12340000; phase[17] = 32'hFF000000;
        frame("t2");
        chk("t2_num", 64'(num), 64'd3);
        chk("t2_mask", 64'(mask), 64'h020202);
        chk("t2_map0", 64'(idx[0]), 64'd1);
        chk("t2_map1", 64'(idx[1]), 64'd9);
        chk("t2_map2", 64'(idx[2]), 64'd17);
        chk("t2_map3", 64'(idx[3]), 64'd31);
        chk("t2_a1", 64'(addr[1]), 64'hAB);
        chk("t2_a9", 64'(addr[9]), 64'h12);
        chk("t2_a17", 64'(addr[17]), 64'hFF);
        chk("t2_ovf", 64'(ovf), 64'd0);
        @(posedge clk); #1 chk("t2_strobe_1cyc", 64'(fv), 64'd0);
        repeat (NG) @(posedge clk); #1;

        // T3: all gates, fixed priority
        gate = '1;
        foreach (phase[i]) phase[i] = {8'(i + 16), 24'h0};
        frame("t3a");
        chk("t3_num", 64'(num), 64'd8);
        chk("t3_mask", 64'(mask), 64'h0000FF);
        chk("t3_drop", 64'(dropped), 64'd16);
        chk("t3_ovf", 64'(ovf), 64'd1);
        chk("t3_a3", 64'(addr[3]), 64'h13);
        chk("t3_a8", 64'(addr[8]), 64'd0);
        chk("t3_map7", 64'(idx[7]), 64'd7);
        frame("t3b");
        chk("t3b_mask", 64'(mask), 64'h0000FF);

        // T4: rotating priority
        rr = 1;
        frame("t4a"); chk("t4a_mask", 64'(mask), 64'h0000FF);
        frame("t4b"); chk("t4b_mask", 64'(mask), 64'h00FF00);
        frame("t4c"); chk("t4c_mask", 64'(mask), 64'hFF0000);
        chk("t4c_drop", 64'(dropped), 64'd16);
        frame("t4d"); chk("t4d_mask", 64'(mask), 64'h0000FF);
        rr = 0;
        frame("t4e"); chk("t4e_mask", 64'(mask), 64'h00FF00);

        // T5: middle group disabled
        gen = 3'b101; gate = '0; gate[8] = 1; gate[10] = 1; gate[16] = 1;
        phase[16] = 32'h5A000000;
        frame("t5");
        chk("t5_num", 64'(num), 64'd1);
        chk("t5_map0", 64'(idx[0]), 64'd16);
        chk("t5_map1", 64'(idx[1]), 64'd31);
        chk("t5_a8", 64'(addr[8]), 64'd0);
        chk("t5_a10", 64'(addr[10]), 64'd0);
        chk("t5_a16", 64'(addr[16]), 64'h5A);
        chk("t5_ovf", 64'(ovf), 64'd0);
        chk("t5_drop", 64'(dropped), 64'd0);

        // T6: reset during SCAN slot 1
        gen = 3'b111; gate = '1;
        @(posedge clk); #1;
        chk("t6_scan_addr0", 64'(addr[0]), 64'h10);
        rst = 1;
        @(posedge clk); #1;
        chk("t6_rst_fv", 64'(fv), 64'd0);
        chk("t6_rst_num", 64'(num), 64'd0);
        chk("t6_rst_addr0", 64'(addr[0]), 64'd0);
        chk("t6_rst_map0", 64'(idx[0]), 64'd31);
        rst = 0;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk); #1;
            chk($sformatf("t6_nostrobe_e%0d", e), 64'(fv), 64'd0);
        end
        @(posedge clk); #1;
        chk("t6_strobe", 64'(fv), 64'd1);
        chk("t6_num", 64'(num), 64'd8);
        $display("frame t6: num=%0d mask=%06h", num, mask);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
